// File: rtl/axi_regfile_gen.sv
// AXI4-Lite slave register file: C_NUM_REGS control words out, C_NUM_REGS status words in,
// with per-register write mask and one-cycle write/read strobes for side-effect registers.
module axi_regfile_gen #(
  parameter int                    C_S_AXI_DATA_WIDTH = 32,
  parameter int                    C_S_AXI_ADDR_WIDTH = 8,
  parameter int                    C_NUM_REGS         = 16,
  parameter logic [C_NUM_REGS-1:0] C_WR_MASK          = '1
) (
  input  logic                                            S_AXI_ACLK,
  input  logic                                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                   S_AXI_AWADDR,
  input  logic [2:0]                                      S_AXI_AWPROT,
  input  logic                                            S_AXI_AWVALID,
  output logic                                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]                   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]                 S_AXI_WSTRB,
  input  logic                                            S_AXI_WVALID,
  output logic                                            S_AXI_WREADY,
  output logic [1:0]                                      S_AXI_BRESP,
  output logic                                            S_AXI_BVALID,
  input  logic                                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                   S_AXI_ARADDR,
  input  logic [2:0]                                      S_AXI_ARPROT,
  input  logic                                            S_AXI_ARVALID,
  output logic                                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]                   S_AXI_RDATA,
  output logic [1:0]                                      S_AXI_RRESP,
  output logic                                            S_AXI_RVALID,
  input  logic                                            S_AXI_RREADY,
  output logic [C_NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0]   slv_reg,
  input  logic [C_NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0]   slv_read,
  output logic [C_NUM_REGS-1:0]                           wr_pulse,
  output logic [C_NUM_REGS-1:0]                           rd_pulse
);

  localparam int ADDR_LSB = (C_S_AXI_DATA_WIDTH == 64) ? 3 : 2;
  localparam int IDX_W    = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
  localparam int NB       = C_S_AXI_DATA_WIDTH / 8;

  logic                          r_aw_full;
  logic [IDX_W-1:0]              r_aw_idx;
  logic                          r_w_full;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_wdata;
  logic [NB-1:0]                 r_wstrb;
  logic                          r_bvalid;
  logic [1:0]                    r_bresp;
  logic                          r_rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
  logic [1:0]                    r_rresp;
  logic [C_NUM_REGS-1:0]         r_wr_pulse;
  logic [C_NUM_REGS-1:0]         r_rd_pulse;

  logic                          w_aw_hs;
  logic                          w_w_hs;
  logic                          w_ar_hs;
  logic                          w_commit;
  logic [IDX_W-1:0]              w_ar_idx;
  logic [C_NUM_REGS-1:0]         w_wr_sel;
  logic [C_NUM_REGS-1:0]         w_rd_sel;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_rd_word;
  logic                          w_unused;

  // Every channel transfers on the cycle where VALID and READY are both high at the clock edge;
  // VALID never waits on READY, and READY here is a pure function of local holding state.
  assign S_AXI_AWREADY = ~r_aw_full;
  assign S_AXI_WREADY  = ~r_w_full;
  assign S_AXI_ARREADY = ~r_rvalid;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign wr_pulse      = r_wr_pulse;
  assign rd_pulse      = r_rd_pulse;

  assign w_aw_hs  = S_AXI_AWVALID & ~r_aw_full;
  assign w_w_hs   = S_AXI_WVALID & ~r_w_full;
  assign w_ar_hs  = S_AXI_ARVALID & ~r_rvalid;
  assign w_commit = r_aw_full & r_w_full & ~r_bvalid;
  assign w_ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
  assign w_unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                      S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  // One-hot selects stay all-zero for indices past the implemented range, which is the range check.
  always_comb begin
    w_wr_sel  = '0;
    w_rd_sel  = '0;
    w_rd_word = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      w_wr_sel[i] = (r_aw_idx == IDX_W'(i));
      w_rd_sel[i] = (w_ar_idx == IDX_W'(i));
      w_rd_word   = w_rd_word | (slv_read[i] & {C_S_AXI_DATA_WIDTH{w_rd_sel[i]}});
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_aw_full  <= 1'b0;
      r_aw_idx   <= '0;
      r_w_full   <= 1'b0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= 2'b00;
      r_wr_pulse <= '0;
    end else begin
      if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_aw_idx  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
      end else if (w_commit) begin
        r_aw_full <= 1'b0;
      end
      if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_wdata  <= S_AXI_WDATA;
        r_wstrb  <= S_AXI_WSTRB;
      end else if (w_commit) begin
        r_w_full <= 1'b0;
      end
      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= (|w_wr_sel) ? 2'b00 : 2'b10;
      end else if (r_bvalid && S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end
      r_wr_pulse <= w_commit ? w_wr_sel : '0;
    end
  end

  // Read-only registers are never loaded, so they stay at their reset value of zero.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      slv_reg <= '0;
    end else if (w_commit) begin
      for (int i = 0; i < C_NUM_REGS; i++) begin
        for (int b = 0; b < NB; b++) begin
          if (w_wr_sel[i] && C_WR_MASK[i] && r_wstrb[b]) begin
            slv_reg[i][8*b +: 8] <= r_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_rresp    <= 2'b00;
      r_rd_pulse <= '0;
    end else begin
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_word;
        r_rresp  <= (|w_rd_sel) ? 2'b00 : 2'b10;
      end else if (r_rvalid && S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
      r_rd_pulse <= w_ar_hs ? w_rd_sel : '0;
    end
  end

endmodule

// File: tb/tb_axi_regfile_gen.sv
// Directed bench for axi_regfile_gen: loopback readback, write ordering, back-pressure,
// out-of-range decode, read-only mask and reset mid-transaction.
module tb_axi_regfile_gen;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NR = 16;

  logic                   clk;
  logic                   rst_n;
  logic [AW-1:0]          awaddr;
  logic [2:0]             awprot;
  logic                   awvalid;
  logic                   awready;
  logic [DW-1:0]          wdata;
  logic [DW/8-1:0]        wstrb;
  logic                   wvalid;
  logic                   wready;
  logic [1:0]             bresp;
  logic                   bvalid;
  logic                   bready;
  logic [AW-1:0]          araddr;
  logic [2:0]             arprot;
  logic                   arvalid;
  logic                   arready;
  logic [DW-1:0]          rdata;
  logic [1:0]             rresp;
  logic                   rvalid;
  logic                   rready;
  logic [NR-1:0][DW-1:0]  slv_reg;
  logic [NR-1:0][DW-1:0]  slv_read;
  logic [NR-1:0]          wr_pulse;
  logic [NR-1:0]          rd_pulse;

  logic [DW-1:0] exp_reg [NR];
  int n_checks;
  int n_errors;

  axi_regfile_gen #(
    .C_S_AXI_DATA_WIDTH (DW),
    .C_S_AXI_ADDR_WIDTH (AW),
    .C_NUM_REGS         (NR),
    .C_WR_MASK          (16'hFFF7)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .slv_reg       (slv_reg),
    .slv_read      (slv_read),
    .wr_pulse      (wr_pulse),
    .rd_pulse      (rd_pulse)
  );

  assign slv_read = slv_reg;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++) check($sformatf("%s_reg%0d", tag, i), slv_reg[i], exp_reg[i]);
  endtask

  // Issue a read; expects RVALID one cycle after the AR handshake with RREADY held high.
  task automatic do_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                         output logic [1:0] resp, output logic [NR-1:0] pulse);
    int n;
    @(negedge clk);
    arvalid = 1'b1;
    araddr  = addr;
    n = 0;
    while (!arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ar_accept_timeout", (n < 20), 1'b1);
    @(negedge clk);
    arvalid = 1'b0;
    check("rvalid_latency", rvalid, 1'b1);
    data  = rdata;
    resp  = rresp;
    pulse = rd_pulse;
    @(negedge clk);
    check("rvalid_clear", rvalid, 1'b0);
    check("rd_pulse_one_cycle", rd_pulse, '0);
  endtask

  task automatic clear_inputs();
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0;
    rready = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [1:0]    r;
    logic [NR-1:0] p;
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < NR; i++) exp_reg[i] = '0;
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset state
    check("rst_awready", awready, 1'b1);
    check("rst_wready", wready, 1'b1);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_arready", arready, 1'b1);
    check("rst_wr_pulse", wr_pulse, '0);
    check_regs("rst");
    for (int i = 0; i < NR; i++) begin
      do_read(AW'(i * 4), d, r, p);
      check($sformatf("rst_rdata%0d", i), d, '0);
      check($sformatf("rst_rresp%0d", i), r, 2'b00);
      check($sformatf("rst_rdpulse%0d", i), p, NR'(1) << i);
    end

    // AW and W in the same cycle
    @(negedge clk);
    awvalid = 1'b1; awaddr = 8'h08;
    wvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    bready = 1'b0;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("t2_awready_held", awready, 1'b0);
    check("t2_bvalid_cycle1", bvalid, 1'b0);
    check("t2_pulse_cycle1", wr_pulse, '0);
    @(negedge clk);
    exp_reg[2] = 32'hDEADBEEF;
    check("t2_bvalid_cycle2", bvalid, 1'b1);
    check("t2_bresp", bresp, 2'b00);
    check("t2_pulse_cycle2", wr_pulse, 16'h0004);
    check_regs("t2");
    @(negedge clk);
    check("t2_pulse_cycle3", wr_pulse, '0);
    check("t2_bvalid_held", bvalid, 1'b1);
    bready = 1'b1;
    @(negedge clk);
    check("t2_bvalid_clear", bvalid, 1'b0);
    bready = 1'b0;

    // W five cycles ahead of AW, then BREADY withheld
    wvalid = 1'b1; wdata = 32'h000000AA; wstrb = 4'h1;
    @(negedge clk);
    wvalid = 1'b0;
    check("t3_wready_full", wready, 1'b0);
    repeat (4) @(negedge clk);
    check("t3_no_commit_bvalid", bvalid, 1'b0);
    check("t3_no_commit_reg", slv_reg[2], 32'hDEADBEEF);
    awvalid = 1'b1; awaddr = 8'h08;
    @(negedge clk);
    awvalid = 1'b0;
    check("t3_bvalid_cycle1", bvalid, 1'b0);
    @(negedge clk);
    exp_reg[2] = 32'hDEADBEAA;
    check("t3_bvalid", bvalid, 1'b1);
    check("t3_bresp", bresp, 2'b00);
    check("t3_pulse", wr_pulse, 16'h0004);
    check_regs("t3");
    awvalid = 1'b1; awaddr = 8'h04;
    wvalid = 1'b1; wdata = 32'h11111111; wstrb = 4'hF;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("t3_bvalid_hold", bvalid, 1'b1);
      check("t3_awready_blocked", awready, 1'b0);
      check("t3_wready_blocked", wready, 1'b0);
      check("t3_second_not_committed", slv_reg[1], '0);
      if (k < 3) @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    check("t3_bvalid_drop", bvalid, 1'b0);
    @(negedge clk);
    exp_reg[1] = 32'h11111111;
    check("t3_next_bvalid", bvalid, 1'b1);
    check("t3_next_pulse", wr_pulse, 16'h0002);
    check_regs("t3b");
    @(negedge clk);
    check("t3_next_bvalid_clear", bvalid, 1'b0);

    // out-of-range write and read
    awvalid = 1'b1; awaddr = 8'h40;
    wvalid = 1'b1; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("t4_bvalid", bvalid, 1'b1);
    check("t4_bresp", bresp, 2'b10);
    check("t4_no_pulse", wr_pulse, '0);
    check_regs("t4");
    do_read(8'h40, d, r, p);
    check("t4_rdata", d, '0);
    check("t4_rresp", r, 2'b10);
    check("t4_no_rdpulse", p, '0);
    do_read(8'h09, d, r, p);
    check("t4_unaligned_rdata", d, 32'hDEADBEAA);
    check("t4_unaligned_rresp", r, 2'b00);
    check("t4_unaligned_rdpulse", p, 16'h0004);

    // read-only register 3
    @(negedge clk);
    awvalid = 1'b1; awaddr = 8'h0C;
    wvalid = 1'b1; wdata = 32'h12345678; wstrb = 4'hF;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("t5_bvalid", bvalid, 1'b1);
    check("t5_bresp", bresp, 2'b00);
    check("t5_pulse", wr_pulse, 16'h0008);
    check_regs("t5");

    // reset between W and AW
    @(negedge clk);
    bready = 1'b0;
    wvalid = 1'b1; wdata = 32'hCAFEF00D; wstrb = 4'hF;
    @(negedge clk);
    wvalid = 1'b0;
    check("t6_w_held", wready, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) exp_reg[i] = '0;
    @(negedge clk);
    check("t6_awready", awready, 1'b1);
    check("t6_wready", wready, 1'b1);
    check("t6_bvalid", bvalid, 1'b0);
    check_regs("t6");
    awvalid = 1'b1; awaddr = 8'h00;
    @(negedge clk);
    awvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_no_bvalid", bvalid, 1'b0);
    check("t6_no_pulse", wr_pulse, '0);
    check("t6_reg0", slv_reg[0], '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
